// File: rtl/counter_sequencer.sv
// Push-button run/stop, direction and rate control for the 4-bit LED counter.
// Presses appear 2 sync + DEBOUNCE_CYCLES cycles after a stable edge; the tick is registered one cycle after the divider wrap.
module counter_sequencer #(
  parameter int CLK_HZ          = 25000000,
  parameter int DIV_BITS        = 25,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CTR_BITS        = 4
) (
  input  logic                clkin,
  input  logic                rstn,
  input  logic                btn_run,
  input  logic                btn_dir,
  input  logic                btn_speed,
  output logic [CTR_BITS-1:0] led,
  output logic                tick,
  output logic                running,
  output logic                dir_down,
  output logic [1:0]          speed
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int B_RUN = 0;
  localparam int B_DIR = 1;
  localparam int B_SPD = 2;

  typedef enum logic {
    STOP = 1'b0,
    RUN  = 1'b1
  } state_t;

  logic [2:0]       btn_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       level;
  logic [2:0]       press;
  logic [DEB_W-1:0] deb_cnt [3];

  state_t              state_q;
  state_t              state_d;
  logic [DIV_BITS-1:0] div_q;
  logic [DIV_BITS-1:0] div_d;
  logic [DIV_BITS-1:0] div_max;
  logic                tick_d;

  assign btn_raw = {btn_speed, btn_dir, btn_run};

  // A level is accepted only after it has disagreed with the current one for
  // DEBOUNCE_CYCLES straight cycles; any bounce back restarts the count.
  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      sync1 <= '0;
      sync2 <= '0;
      level <= '0;
      press <= '0;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_cnt[i] <= '0;
          level[i]   <= sync2[i];
          press[i]   <= sync2[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
        end
      end
    end
  end

  assign div_max = (DIV_BITS'(CLK_HZ) >> speed) - DIV_BITS'(1);

  // Stop and speed presses take priority over a divider wrap, so the tick is dropped.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    case (state_q)
      STOP: begin
        if (press[B_RUN]) state_d = RUN;
        if (press[B_RUN] || press[B_SPD]) div_d = '0;
      end
      RUN: begin
        if (press[B_RUN]) begin
          state_d = STOP;
        end else if (press[B_SPD]) begin
          div_d = '0;
        end else if (div_q == div_max) begin
          div_d  = '0;
          tick_d = 1'b1;
        end else begin
          div_d = div_q + DIV_BITS'(1);
        end
      end
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clkin or negedge rstn) begin
    if (!rstn) begin
      state_q  <= STOP;
      div_q    <= '0;
      tick     <= 1'b0;
      led      <= '0;
      dir_down <= 1'b0;
      speed    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick     <= tick_d;
      speed    <= speed + {1'b0, press[B_SPD]};
      dir_down <= dir_down ^ press[B_DIR];
      // Step uses the direction held before any same-cycle dir press lands.
      if (tick) led <= dir_down ? led - CTR_BITS'(1) : led + CTR_BITS'(1);
    end
  end

  assign running = (state_q == RUN);

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controls the LED counter datapath from the board's push-buttons. Three buttons set run/stop, count direction and count rate.
- Generates single-cycle tick enables from a programmable divider of `clkin`. No derived clocks.
- Steps a 4-bit counter that drives the LED bank. It replaces the fixed 1 Hz free-running counter at the top level.

Parameters:
- CLK_HZ, 25000000, input clock frequency. Divisor for speed 0; one tick per second.
- DIV_BITS, 25, width of the tick divider; must satisfy 2^DIV_BITS > CLK_HZ.
- DEBOUNCE_CYCLES, 250000, cycles a synchronized button level must stay stable before it is accepted (10 ms at 25 MHz).
- CTR_BITS, 4, counter and LED width.

Ports:
- clkin  in  1  system clock; all logic on posedge.
- rstn  in  1  asynchronous active-low reset.
- btn_run  in  1  raw run/stop button; asynchronous, active high.
- btn_dir  in  1  raw direction button; asynchronous, active high.
- btn_speed  in  1  raw speed button; asynchronous, active high.
- led  out  CTR_BITS  counter value.
- tick  out  1  one-cycle pulse on each count step.
- running  out  1  1 when in RUN state.
- dir_down  out  1  0 = count up, 1 = count down.
- speed  out  2  current rate select, 0..3.

Behaviour:
- Reset (rstn low, asynchronous): all outputs 0, FSM in STOP, divider 0, debounce state 0.
- Release of reset is synchronous to `clkin`.

Button input path (identical for each button):
- 2-flop synchronizer, then a debounce counter.
- The accepted level changes only after the synchronized level has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- A 0->1 transition of the accepted level yields a one-cycle press pulse.
- Release generates nothing.
- Holding a button produces exactly one pulse.

FSM, states STOP and RUN:
- STOP + run press -> RUN; divider cleared to 0.
- RUN + run press -> STOP; divider frozen; counter holds.
- In STOP, tick stays 0.
- STOP->RUN->STOP restarts timing from 0 on the next entry into RUN.

Direction:
- A dir press toggles dir_down in any state, effective the next cycle.
- If a dir press and a tick occur in the same cycle, that tick uses the old direction.

Speed:
- A speed press increments speed modulo 4 (3 -> 0) and clears the divider to 0 in the same cycle.
- Divisor = CLK_HZ >> speed, i.e. CLK_HZ, /2, /4, /8.

Divider (RUN only):
- Counts 0..divisor-1 and wraps to 0.
- tick is registered: it is 1 for the cycle after the divider holds divisor-1.
- Press pulse at cycle N (STOP->RUN): running=1 at N+1; first tick at N+1+divisor; led updates on the cycle tick is high (visible at N+2+divisor).
- Tick period is exactly divisor cycles.

Counter:
- On tick: up gives led+1, wrapping 15->0; down gives led-1, wrapping 0->15.
- All arithmetic is mod 2^CTR_BITS.

Simultaneous events:
- Run press (RUN->STOP) in the same cycle as a divider wrap: the stop wins. No tick is issued and led is unchanged.
- Speed press in the same cycle as a divider wrap: the speed change wins. Divider is cleared and no tick is issued.
- Presses on different buttons in the same cycle are all applied.

Reset mid-operation: immediate return to reset values, including a tick in flight.

Test Plan (CLK_HZ=16, DEBOUNCE_CYCLES=4, DIV_BITS=5):
1. Reset, no presses, 200 cycles -> led=0, tick never 1, running=0.
2. Clean run press -> press pulse 6 cycles after the edge (2 sync + 4 debounce); running=1 next cycle. tick every 16 cycles; led 0,1,2,...,15,0 (wrap checked).
3. btn_run bounces 1-0-1-0 at 2-cycle spacing, then holds high 20 cycles -> exactly one press pulse, running=1; no toggle back.
4. In RUN at led=0, press dir -> dir_down=1; next tick led=15, then 14. Also press dir in the cycle a tick is issued -> that step uses the old direction.
5. In RUN, press speed three times -> speed=1,2,3. Tick intervals 8, 4, 2 cycles; divider restarts at each press. A fourth press gives speed=0, interval 16.
6. RUN with led=5, assert rstn low for 1 cycle mid-interval -> all outputs 0 immediately. Press run again -> first tick 16 cycles after entering RUN.
